// File: rtl/mux_seq_nto1.sv
// mux_seq_nto1 : registered N:1 channel selector with direct and scan modes.
//
// Direct mode passes channel[sel] to y one cycle later. Scan mode steps
// round-robin through all channels and holds each one for dwell+1 cycles.
// Every output is registered, so there is no combinational path from x or sel
// to y.
//
// Ports:
//   clk, rst_n    rising-edge clock; asynchronous active-low reset
//   x             packed channels, channel i = x[i*WIDTH +: WIDTH]
//   sel           direct-mode channel index
//   mode          0 = direct, 1 = scan
//   en            run enable; 0 freezes all state (y_valid drops)
//   dwell         scan-mode hold time minus one
//   y, y_valid    registered sample and its valid flag
//   cur_sel       index of the channel that produced y
//   wrap          one-cycle pulse when scan output returns from CHANNELS-1 to 0
//   sel_err       direct-mode sel >= CHANNELS (y is forced to 0)
//
// Optional build macro MUX_SEQ_PARITY_EN adds y_par, the XOR reduction of y.
module mux_seq_nto1 #(
  parameter int CHANNELS = 16,
  parameter int WIDTH    = 1,
  parameter int SEL_W    = $clog2(CHANNELS),
  parameter int DWELL_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] x,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      mode,
  input  logic                      en,
  input  logic [DWELL_W-1:0]        dwell,
  output logic [WIDTH-1:0]          y,
  output logic                      y_valid,
  output logic [SEL_W-1:0]          cur_sel,
  output logic                      wrap,
  output logic                      sel_err
`ifdef MUX_SEQ_PARITY_EN
  ,
  output logic                      y_par
`endif
);

  typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_e;

  localparam logic [SEL_W-1:0] LAST = SEL_W'(CHANNELS - 1);

  logic [CHANNELS-1:0][WIDTH-1:0] ch;
  assign ch = x;

  state_e             state_q, state_d;
  logic               paused_q, paused_d;   // IDLE reached by pausing a scan
  logic [SEL_W-1:0]   idx_q, idx_d;         // channel to show on the next scan edge
  logic [DWELL_W-1:0] cnt_q, cnt_d;         // edges that idx_q has already been shown
  logic [WIDTH-1:0]   y_q, y_d;
  logic               vld_q, vld_d;
  logic [SEL_W-1:0]   cs_q, cs_d;
  logic               wrap_q, wrap_d;
  logic               err_q, err_d;

  logic               sel_ill;
  logic [SEL_W-1:0]   sel_safe;
  logic               restart;
  logic [SEL_W-1:0]   idx_eff;
  logic [DWELL_W-1:0] cnt_eff;

  // Compare one bit wider so that CHANNELS == 2**SEL_W does not overflow.
  assign sel_ill  = ({1'b0, sel} >= (SEL_W+1)'(CHANNELS));
  assign sel_safe = sel_ill ? '0 : sel;

  always_comb begin
    state_d  = state_q;
    paused_d = paused_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    y_d      = y_q;
    vld_d    = 1'b0;
    cs_d     = cs_q;
    wrap_d   = 1'b0;
    err_d    = err_q;
    restart  = 1'b0;
    idx_eff  = idx_q;
    cnt_eff  = cnt_q;

    if (!en) begin
      state_d = IDLE;
      if (state_q == SCAN) paused_d = 1'b1;
    end else if (!mode) begin
      state_d  = DIRECT;
      paused_d = 1'b0;
      cs_d     = sel;
      if (sel_ill) begin
        y_d   = '0;
        err_d = 1'b1;
      end else begin
        y_d   = ch[sel_safe];
        err_d = 1'b0;
        vld_d = 1'b1;
      end
    end else begin
      state_d  = SCAN;
      paused_d = 1'b0;
      // A fresh entry restarts at channel 0; a paused scan resumes in place.
      restart  = (state_q != SCAN) && !(state_q == IDLE && paused_q);
      if (restart) begin
        idx_eff = '0;
        cnt_eff = '0;
      end
      y_d    = ch[idx_eff];
      cs_d   = idx_eff;
      vld_d  = 1'b1;
      err_d  = 1'b0;
      wrap_d = !restart && (cs_q == LAST) && (idx_eff == '0);
      // >= rather than == so a dwell shortened below the running count
      // advances immediately instead of waiting for the counter to roll over.
      if (cnt_eff >= dwell) begin
        cnt_d = '0;
        idx_d = (idx_eff == LAST) ? '0 : idx_eff + 1'b1;
      end else begin
        cnt_d = cnt_eff + 1'b1;
        idx_d = idx_eff;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      paused_q <= 1'b0;
      idx_q    <= '0;
      cnt_q    <= '0;
      y_q      <= '0;
      vld_q    <= 1'b0;
      cs_q     <= '0;
      wrap_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      paused_q <= paused_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      y_q      <= y_d;
      vld_q    <= vld_d;
      cs_q     <= cs_d;
      wrap_q   <= wrap_d;
      err_q    <= err_d;
    end
  end

  assign y       = y_q;
  assign y_valid = vld_q;
  assign cur_sel = cs_q;
  assign wrap    = wrap_q;
  assign sel_err = err_q;

`ifdef MUX_SEQ_PARITY_EN
  logic par_q;

  // Parity follows y_d, so it is 0 whenever y is forced to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_q <= 1'b0;
    else        par_q <= ^y_d;
  end

  assign y_par = par_q;
`endif

endmodule

// File: tb/tb_mux_seq_nto1.sv
module tb_mux_seq_nto1;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  localparam int ND = 3;  // 0: 16x1, 1: 4x8, 2: 12x8

  int checks = 0;
  int errors = 0;

  logic [7:0] chv [ND][16];
  logic       en_r [ND];
  logic       mode_r [ND];
  logic [3:0] sel_r [ND];
  logic [7:0] dwell_r [ND];

  logic [15:0] x16;
  logic [31:0] x4;
  logic [95:0] x12;
  always_comb for (int i = 0; i < 16; i++) x16[i] = chv[0][i][0];
  always_comb for (int i = 0; i < 4; i++)  x4[i*8 +: 8] = chv[1][i];
  always_comb for (int i = 0; i < 12; i++) x12[i*8 +: 8] = chv[2][i];

  logic       y16, v16, w16, e16, v4, w4, e4, v12, w12, e12;
  logic [7:0] y4, y12;
  logic [3:0] cs16, cs12;
  logic [1:0] cs4;
`ifdef MUX_SEQ_PARITY_EN
  logic p16, p4, p12;
`endif

  mux_seq_nto1 #(.CHANNELS(16), .WIDTH(1)) u16 (
    .clk(clk), .rst_n(rst_n), .x(x16), .sel(sel_r[0]), .mode(mode_r[0]), .en(en_r[0]),
    .dwell(dwell_r[0]), .y(y16), .y_valid(v16), .cur_sel(cs16), .wrap(w16), .sel_err(e16)
`ifdef MUX_SEQ_PARITY_EN
    , .y_par(p16)
`endif
  );

  mux_seq_nto1 #(.CHANNELS(4), .WIDTH(8)) u4 (
    .clk(clk), .rst_n(rst_n), .x(x4), .sel(sel_r[1][1:0]), .mode(mode_r[1]), .en(en_r[1]),
    .dwell(dwell_r[1]), .y(y4), .y_valid(v4), .cur_sel(cs4), .wrap(w4), .sel_err(e4)
`ifdef MUX_SEQ_PARITY_EN
    , .y_par(p4)
`endif
  );

  mux_seq_nto1 #(.CHANNELS(12), .WIDTH(8)) u12 (
    .clk(clk), .rst_n(rst_n), .x(x12), .sel(sel_r[2]), .mode(mode_r[2]), .en(en_r[2]),
    .dwell(dwell_r[2]), .y(y12), .y_valid(v12), .cur_sel(cs12), .wrap(w12), .sel_err(e12)
`ifdef MUX_SEQ_PARITY_EN
    , .y_par(p12)
`endif
  );

  // Observed outputs gathered per DUT: {y, valid, cur_sel, wrap, sel_err}.
  logic [18:0] obs [ND];
  always_comb begin
    obs[0] = {7'b0, y16, v16, 4'b0, cs16, w16, e16};
    obs[1] = {y4, v4, 6'b0, cs4, w4, e4};
    obs[2] = {y12, v12, 4'b0, cs12, w12, e12};
  end

  // Behavioural model: what was last shown and where the scan stands.
  typedef struct {
    int st;        // 0 idle, 1 direct, 2 scan
    bit paused;
    int idx;       // next channel a scan shows
    int cnt;       // times idx has already been shown
    logic [7:0] y;
    bit vld;
    int cs;
    bit wrap;
    bit err;
  } mdl_t;
  mdl_t m [ND];

  function automatic int nch_of(input int k);
    return (k == 0) ? 16 : (k == 1) ? 4 : 12;
  endfunction

  function automatic mdl_t mstep(input mdl_t s, input int k);
    mdl_t r = s;
    int   nch = nch_of(k);
    int   sel = int'(sel_r[k]);
    bit   fresh;
    r.wrap = 1'b0;
    if (!en_r[k]) begin
      if (s.st == 2) r.paused = 1'b1;
      r.st = 0;
      r.vld = 1'b0;
    end else if (!mode_r[k]) begin
      r.st = 1; r.paused = 1'b0; r.cs = sel;
      if (sel >= nch) begin r.y = 8'h00; r.err = 1'b1; r.vld = 1'b0; end
      else begin r.y = chv[k][sel]; r.err = 1'b0; r.vld = 1'b1; end
    end else begin
      fresh = !(s.st == 2 || (s.st == 0 && s.paused));
      if (fresh) begin r.idx = 0; r.cnt = 0; end
      r.st = 2; r.paused = 1'b0;
      r.y = chv[k][r.idx]; r.vld = 1'b1; r.err = 1'b0;
      r.wrap = !fresh && s.cs == nch - 1 && r.idx == 0;
      r.cs = r.idx;
      r.cnt = r.cnt + 1;
      if (r.cnt > int'(dwell_r[k])) begin r.cnt = 0; r.idx = (r.idx + 1) % nch; end
    end
    return r;
  endfunction

  function automatic logic [18:0] mexp(input int k);
    return {m[k].y, m[k].vld, 8'(m[k].cs), m[k].wrap, m[k].err};
  endfunction

  task automatic mreset();
    for (int k = 0; k < ND; k++) m[k] = '{0, 1'b0, 0, 0, 8'h00, 1'b0, 0, 1'b0, 1'b0};
  endtask

  // One clock: DUT and model both consume the inputs present at the edge.
  task automatic cyc();
    @(posedge clk);
    for (int k = 0; k < ND; k++) m[k] = mstep(m[k], k);
    @(negedge clk);
  endtask

  task automatic test_reset();
    int n;
    #1;
    for (int k = 0; k < ND; k++) begin
      checks++;
      if (obs[k] !== 19'h0) begin
        errors++; $display("FAIL reset_init dut%0d got %h want 0", k, obs[k]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    en_r[0] = 1'b1; mode_r[0] = 1'b1; dwell_r[0] = 8'd0;
    n = 0;
    while (m[0].cs != 5 && n < 20) begin
      cyc(); n++;
      checks++;
      if (obs[0] !== mexp(0)) begin
        errors++; $display("FAIL reset_prescan got %h want %h", obs[0], mexp(0));
      end
    end
    checks++;
    if (n >= 20) begin errors++; $display("FAIL reset_reach5 got timeout want cur_sel 5"); end
    #2 rst_n = 1'b0;
    #1;
    mreset();
    for (int k = 0; k < ND; k++) begin
      checks++;
      if (obs[k] !== 19'h0) begin
        errors++; $display("FAIL reset_async dut%0d got %h want 0", k, obs[k]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    checks++;
    if (y16 !== chv[0][0][0] || cs16 !== 4'd0 || v16 !== 1'b1 || obs[0] !== mexp(0)) begin
      errors++; $display("FAIL reset_first got %h want %h", obs[0], mexp(0));
    end
  endtask

  task automatic test_direct_sweep();
    logic [15:0] pat;
    pat = 16'hA5C3;
    for (int i = 0; i < 16; i++) chv[0][i] = {7'b0, pat[i]};
    en_r[0] = 1'b1; mode_r[0] = 1'b0;
    for (int i = 0; i < 16; i++) begin
      sel_r[0] = 4'(i);
      cyc();
      checks++;
      if (y16 !== pat[i] || v16 !== 1'b1 || e16 !== 1'b0 || cs16 !== 4'(i)) begin
        errors++; $display("FAIL direct_sweep sel=%0d got y=%b v=%b e=%b cs=%0d want y=%b v=1 e=0", i, y16, v16, e16, cs16, pat[i]);
      end
    end
  endtask

  task automatic test_scan();
    logic [7:0] ey;
    chv[1][0] = 8'h11; chv[1][1] = 8'h22; chv[1][2] = 8'h33; chv[1][3] = 8'h44;
    en_r[1] = 1'b1; mode_r[1] = 1'b1; dwell_r[1] = 8'd2;
    for (int n = 0; n < 15; n++) begin
      cyc();
      ey = 8'h11 * 8'((n / 3) % 4 + 1);
      checks++;
      if (y4 !== ey || cs4 !== 2'((n / 3) % 4) || v4 !== 1'b1 || w4 !== (n == 12)) begin
        errors++; $display("FAIL scan n=%0d got y=%h cs=%0d v=%b w=%b want y=%h cs=%0d w=%b", n, y4, cs4, v4, w4, ey, (n / 3) % 4, n == 12);
      end
    end
  endtask

  task automatic test_pause();
    int n;
    logic [7:0] ey [3];
    n = 0;
    while (!(m[1].cs == 2 && m[1].cnt == 1) && n < 20) begin
      cyc(); n++;
      checks++;
      if (obs[1] !== mexp(1)) begin
        errors++; $display("FAIL pause_pre got %h want %h", obs[1], mexp(1));
      end
    end
    checks++;
    if (n >= 20) begin errors++; $display("FAIL pause_reach2 got timeout want cur_sel 2"); end
    en_r[1] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      checks++;
      if (y4 !== 8'h33 || cs4 !== 2'd2 || v4 !== 1'b0 || w4 !== 1'b0) begin
        errors++; $display("FAIL pause_hold i=%0d got y=%h cs=%0d v=%b want y=33 cs=2 v=0", i, y4, cs4, v4);
      end
    end
    en_r[1] = 1'b1;
    ey = '{8'h33, 8'h33, 8'h44};
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++;
      if (y4 !== ey[i] || v4 !== 1'b1 || obs[1] !== mexp(1)) begin
        errors++; $display("FAIL pause_resume i=%0d got y=%h v=%b want y=%h v=1", i, y4, v4, ey[i]);
      end
    end
  endtask

  task automatic test_dwell_shrink();
    logic [7:0] ey [4];
    mode_r[1] = 1'b0; sel_r[1] = 4'd0;
    cyc();
    mode_r[1] = 1'b1; dwell_r[1] = 8'd5;
    for (int i = 0; i < 4; i++) cyc();
    checks++;
    if (y4 !== 8'h11 || cs4 !== 2'd0) begin
      errors++; $display("FAIL shrink_pre got y=%h cs=%0d want y=11 cs=0", y4, cs4);
    end
    dwell_r[1] = 8'd1;
    ey = '{8'h11, 8'h22, 8'h22, 8'h33};
    for (int i = 0; i < 4; i++) begin
      cyc();
      checks++;
      if (y4 !== ey[i] || obs[1] !== mexp(1)) begin
        errors++; $display("FAIL dwell_shrink i=%0d got y=%h want y=%h", i, y4, ey[i]);
      end
    end
  endtask

`ifdef MUX_SEQ_PARITY_EN
  task automatic test_parity();
    chv[1][0] = 8'h07; chv[1][1] = 8'h03;
    en_r[1] = 1'b1; mode_r[1] = 1'b0; sel_r[1] = 4'd0;
    cyc();
    checks++;
    if (p4 !== 1'b1) begin errors++; $display("FAIL parity_07 got %b want 1", p4); end
    sel_r[1] = 4'd1;
    cyc();
    checks++;
    if (p4 !== 1'b0) begin errors++; $display("FAIL parity_03 got %b want 0", p4); end
  endtask
`endif

  task automatic test_illegal_sel();
    for (int i = 0; i < 12; i++) chv[2][i] = 8'($urandom_range(1, 255));
    en_r[2] = 1'b1; mode_r[2] = 1'b0; sel_r[2] = 4'd13;
    cyc();
    checks++;
    if (y12 !== 8'h00 || e12 !== 1'b1 || v12 !== 1'b0) begin
      errors++; $display("FAIL illegal_sel got y=%h e=%b v=%b want y=00 e=1 v=0", y12, e12, v12);
    end
`ifdef MUX_SEQ_PARITY_EN
    checks++;
    if (p12 !== 1'b0) begin errors++; $display("FAIL illegal_par got %b want 0", p12); end
`endif
    sel_r[2] = 4'd3;
    cyc();
    checks++;
    if (y12 !== chv[2][3] || e12 !== 1'b0 || v12 !== 1'b1 || cs12 !== 4'd3) begin
      errors++; $display("FAIL illegal_recover got y=%h e=%b cs=%0d want y=%h e=0 cs=3", y12, e12, cs12, chv[2][3]);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      for (int k = 0; k < ND; k++) begin
        en_r[k] = ($urandom_range(7) != 0);
        if ($urandom_range(9) == 0) mode_r[k] = ~mode_r[k];
        sel_r[k] = (k == 1) ? 4'($urandom_range(3)) : 4'($urandom_range(15));
        if ($urandom_range(5) == 0) dwell_r[k] = 8'($urandom_range(3));
        chv[k][$urandom_range(nch_of(k) - 1)] = (k == 0) ? 8'($urandom_range(1)) : 8'($urandom_range(255));
      end
      cyc();
      for (int k = 0; k < ND; k++) begin
        checks++;
        if (obs[k] !== mexp(k)) begin
          errors++; $display("FAIL random n=%0d dut%0d got %h want %h", n, k, obs[k], mexp(k));
        end
      end
    end
  endtask

  initial begin
    for (int k = 0; k < ND; k++) begin
      for (int i = 0; i < 16; i++) chv[k][i] = (k == 0) ? 8'(i & 1) : 8'(i * 16 + k);
      en_r[k] = 1'b0; mode_r[k] = 1'b0; sel_r[k] = 4'd0; dwell_r[k] = 8'd0;
    end
    mreset();
    test_reset();
    test_direct_sweep();
    test_scan();
    test_pause();
    test_dwell_shrink();
`ifdef MUX_SEQ_PARITY_EN
    test_parity();
`endif
    test_illegal_sel();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mux_seq_nto1.md
Name: mux_seq_nto1

Overview:
- Parametrised, registered N:1 data selector; successor to the lab's 16:1 single-bit combinational selector.
- Generalised in channel count and data width.
- Adds two modes:
  - Direct mode: external select.
  - Scan mode: autonomous round-robin with programmable dwell time.
- Output is registered with a valid flag. Sits between parallel sensor/data channels and a single downstream consumer.

Parameters:
- CHANNELS, 16, number of input channels (2..256).
- WIDTH, 1, bits per channel.
- SEL_W, $clog2(CHANNELS), select width (derived; not overridden).
- DWELL_W, 8, width of dwell counter/input.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- x  input  CHANNELS*WIDTH  packed channels; channel i = x[i*WIDTH +: WIDTH]; with WIDTH=1, channel i = x[i].
- sel  input  SEL_W  channel index used in direct mode.
- mode  input  1  0 = direct, 1 = scan.
- en  input  1  run enable; 0 freezes all state.
- dwell  input  DWELL_W  scan mode: each channel held for dwell+1 cycles.
- y  output  WIDTH  registered selected data.
- y_valid  output  1  y holds a valid sample this cycle.
- cur_sel  output  SEL_W  channel index that produced the current y.
- wrap  output  1  one-cycle pulse when scan returns from channel CHANNELS-1 to 0.
- sel_err  output  1  registered; direct-mode sel >= CHANNELS.

Behaviour:
- Reset (rst_n low, asynchronous): y=0, y_valid=0, cur_sel=0, wrap=0, sel_err=0. Dwell counter = 0, state = IDLE.
- States: IDLE, DIRECT, SCAN.
  - IDLE -> DIRECT when en=1 and mode=0.
  - IDLE -> SCAN when en=1 and mode=1.
  - DIRECT <-> SCAN on a mode change while en=1, taking effect the next edge.
  - Any state -> IDLE when en=0.
- IDLE: y, cur_sel and sel_err hold; y_valid=0; wrap=0.
- DIRECT (latency 1 cycle):
  - Each edge: y <= channel[sel], cur_sel <= sel, y_valid <= 1.
  - sel >= CHANNELS (only possible when CHANNELS is not a power of 2): y <= 0, sel_err <= 1, y_valid <= 0. Otherwise sel_err <= 0.
- SCAN:
  - Entry from IDLE or DIRECT: scan index = 0, dwell counter = 0, first sample on the next edge.
  - Each edge: y <= channel[scan index], cur_sel <= scan index, y_valid <= 1.
  - Dwell counter increments each cycle.
  - When dwell counter == dwell:
    - counter clears and scan index advances.
    - if scan index == CHANNELS-1, it wraps to 0 and wrap pulses 1 on the same edge the index returns to 0.
  - dwell = 0: new channel every cycle.
  - dwell changed mid-dwell: the new value is compared immediately. If counter > new dwell, the advance happens when the counter is next cleared by wrap-around of the DWELL_W counter. The implementation must instead compare with >= so the advance happens on the next edge; the bench checks the >= behaviour.
  - sel_err is forced to 0 in SCAN.
- en deasserted mid-scan: scan index and dwell counter hold. Re-enable in SCAN continues from the held index; it does not restart.
- Simultaneous en rise and mode=1: entry to SCAN from IDLE restarts at index 0 unless the previous state was a paused SCAN; that resume takes priority.
- x is sampled only at the clock edge; there is no combinational path from x or sel to y.

Optional Feature:
- MUX_SEQ_PARITY_EN
- Defined:
  - extra output y_par (1 bit) = registered even parity (XOR reduction) of the value loaded into y, same cycle as y.
  - reset value 0.
  - y_par is 0 whenever y is forced to 0 by sel_err.
- Undefined: port y_par is absent; no parity logic.

Test Plan:
- Reset: rst_n=0 mid-scan at cur_sel=5 -> outputs all zero immediately (asynchronous); after release with en=1, mode=1, first y = channel 0.
- Direct sweep, CHANNELS=16, WIDTH=1: x=16'hA5C3, sel stepped 0..15 -> y equals x[sel] one cycle later; y_valid=1; sel_err=0.
- Scan, dwell=2, CHANNELS=4, WIDTH=8: channels 8'h11, 8'h22, 8'h33, 8'h44 -> each value held 3 cycles in order 11,22,33,44,11; wrap=1 exactly on the edge where cur_sel goes 3->0.
- Pause/resume: en=0 at cur_sel=2 for 5 cycles -> y and cur_sel frozen, y_valid=0; en=1 -> resumes at channel 2 with the dwell count preserved.
- Illegal select, CHANNELS=12: sel=13 in direct mode -> y=0, sel_err=1, y_valid=0; sel=3 next -> sel_err=0, y=channel 3.
- MUX_SEQ_PARITY_EN defined, WIDTH=8: channel value 8'h07 selected -> y_par=1; 8'h03 -> y_par=0.
